// File: rtl/dot_accumulate_pkg.sv
// Shared types and default widths for the dot-product accumulator slice.
package dot_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } dot_acc_state_t;

  localparam int DOT_ACC_WIDTH = 40;
  localparam int DOT_CNT_WIDTH = 16;

endpackage

// File: rtl/dot_accumulate_if.sv
// Issue handshake, multiplier product and result handshake of dot_accumulate.
interface dot_accumulate_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
);

  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_last, product, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_last, product, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

endinterface

// File: rtl/dot_accumulate_valid_delay_line.sv
// Fixed-latency shift register of qualifier bits, cleared by reset so that
// unreset datapath contents are never qualified.
module valid_delay_line #(
  parameter int DEPTH = 5,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/dot_accumulate.sv
// Sums the products of a variable-length vector leaving a pipelined multiplier
// and presents the total on a valid/ready result interface.
module dot_accumulate
  import dot_acc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 5,
  parameter int ACC_WIDTH   = DOT_ACC_WIDTH,
  parameter int CNT_WIDTH   = DOT_CNT_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  dot_accumulate_if.slave bus
);

  dot_acc_state_t       state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 ovf;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [2*WIDTH-1:0]   prod;
  logic [1:0]           tap;
  logic                 tap_valid;
  logic                 tap_last;
  logic                 beat;

  assign prod         = bus.product;
  assign bus.in_ready = (state == IDLE) || (state == ACCUM);
  assign beat         = bus.in_valid && bus.in_ready;
  assign tap_valid    = tap[1];
  assign tap_last     = tap[0];

  valid_delay_line #(
    .DEPTH (PIPE_STAGES),
    .W     (2)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({beat, beat & bus.in_last}),
    .q     (tap)
  );

  // Extra MSB of sum_ext is the carry out of the ACC_WIDTH add.
  always_comb begin
    sum_ext    = {1'b0, acc} + (ACC_WIDTH+1)'(prod);
    count_next = (&count) ? count : count + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      acc              <= '0;
      count            <= '0;
      ovf              <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_sum      <= '0;
      bus.out_count    <= '0;
      bus.out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (beat) state <= bus.in_last ? DRAIN : ACCUM;
        ACCUM:   if (beat && bus.in_last) state <= DRAIN;
        DRAIN:   if (tap_valid && tap_last) state <= HOLD;
        HOLD: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (tap_valid) begin
        if (tap_last) begin
          bus.out_sum      <= sum_ext[ACC_WIDTH-1:0];
          bus.out_count    <= count_next;
          bus.out_overflow <= ovf | sum_ext[ACC_WIDTH];
          bus.out_valid    <= 1'b1;
          acc              <= '0;
          count            <= '0;
          ovf              <= 1'b0;
        end else begin
          acc   <= sum_ext[ACC_WIDTH-1:0];
          count <= count_next;
          ovf   <= ovf | sum_ext[ACC_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_accumulate.sv
// Directed bench for dot_accumulate: a 40-bit and a 32-bit accumulator share one
// stimulus stream fed through a behavioural 5-stage multiplier.
module tb_dot_accumulate;

  localparam int WIDTH = 16;
  localparam int PIPE  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [31:0]      mpipe [PIPE];
  int               cycle = 0;

  dot_accumulate_if #(.WIDTH(WIDTH), .ACC_WIDTH(40), .CNT_WIDTH(16)) bus0 ();
  dot_accumulate_if #(.WIDTH(WIDTH), .ACC_WIDTH(32), .CNT_WIDTH(16)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_last   = in_last;
  assign bus0.out_ready = out_ready;
  assign bus0.product   = mpipe[PIPE-1];
  assign bus1.in_valid  = in_valid;
  assign bus1.in_last   = in_last;
  assign bus1.out_ready = out_ready;
  assign bus1.product   = mpipe[PIPE-1];

  dot_accumulate #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE), .ACC_WIDTH(40), .CNT_WIDTH(16))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dot_accumulate #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE), .ACC_WIDTH(32), .CNT_WIDTH(16))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Behavioural multiplier: operands in cycle t give the product in cycle t+PIPE.
  always @(posedge clk) begin
    mpipe[0] <= op_a * op_b;
    for (int i = 1; i < PIPE; i++) mpipe[i] <= mpipe[i-1];
    cycle <= cycle + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic last,
                       output int t);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_last  = last;
    op_a     = a;
    op_b     = b;
    t        = cycle;
    check("in_ready_at_issue", bus0.in_ready, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input int t_last);
    bit ok = 0;
    bit rdy_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus0.in_ready) rdy_seen = 1;
      if (bus0.out_valid) begin
        ok = 1;
        break;
      end
    end
    check("result_timeout", ok, 1'b1);
    check("latency", cycle - t_last, PIPE + 1);
    check("in_ready_low_drain", rdy_seen, 1'b0);
    check("dut1_out_valid", bus1.out_valid, 1'b1);
  endtask

  task automatic release_result();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_during_ack", bus0.out_valid, 1'b1);
    check("in_ready_during_ack", bus0.in_ready, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_after_ack", bus0.out_valid, 1'b0);
    check("in_ready_after_ack", bus0.in_ready, 1'b1);
  endtask

  typedef struct {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    int               n;
    logic [63:0]      sum0;
    logic             ovf0;
    logic [63:0]      sum1;
    logic             ovf1;
    logic [63:0]      cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int t;
    int t_last;
    bit seen;
    logic [63:0] s0;
    logic [63:0] c0;

    vecs[0] = '{a: {16'd0, 16'd0, 16'd0, 16'd3}, b: {16'd0, 16'd0, 16'd0, 16'd4}, n: 1,
                sum0: 64'd12, ovf0: 1'b0, sum1: 64'd12, ovf1: 1'b0, cnt: 64'd1};
    vecs[1] = '{a: {16'd7, 16'd5, 16'd3, 16'd1}, b: {16'd8, 16'd6, 16'd4, 16'd2}, n: 4,
                sum0: 64'd100, ovf0: 1'b0, sum1: 64'd100, ovf1: 1'b0, cnt: 64'd4};
    vecs[2] = '{a: {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, b: {16'd0, 16'd0, 16'hFFFF, 16'hFFFF},
                n: 2, sum0: 64'h1_FFFC_0002, ovf0: 1'b0, sum1: 64'hFFFC_0002, ovf1: 1'b1,
                cnt: 64'd2};
    vecs[3] = '{a: {16'd0, 16'd0, 16'd0, 16'd1}, b: {16'd0, 16'd0, 16'd0, 16'd1}, n: 1,
                sum0: 64'd1, ovf0: 1'b0, sum1: 64'd1, ovf1: 1'b0, cnt: 64'd1};
    vecs[4] = '{a: {16'd0, 16'd0, 16'd9, 16'd0}, b: {16'd0, 16'd0, 16'd0, 16'd5}, n: 2,
                sum0: 64'd0, ovf0: 1'b0, sum1: 64'd0, ovf1: 1'b0, cnt: 64'd2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_out_sum", bus0.out_sum, 64'd0);
    check("rst_out_count", bus0.out_count, 64'd0);
    check("rst_out_overflow", bus0.out_overflow, 1'b0);
    check("rst_in_ready", bus0.in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven vectors (single beat, back-to-back, 32-bit wrap, post-wrap, zeros)
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n; j++) begin
        issue(vecs[v].a[j], vecs[v].b[j], j == vecs[v].n - 1, t);
      end
      t_last = t;
      idle();
      wait_result(t_last);
      check($sformatf("v%0d_sum0", v), bus0.out_sum, vecs[v].sum0);
      check($sformatf("v%0d_ovf0", v), bus0.out_overflow, vecs[v].ovf0);
      check($sformatf("v%0d_cnt0", v), bus0.out_count, vecs[v].cnt);
      check($sformatf("v%0d_sum1", v), bus1.out_sum, vecs[v].sum1);
      check($sformatf("v%0d_ovf1", v), bus1.out_overflow, vecs[v].ovf1);
      check($sformatf("v%0d_cnt1", v), bus1.out_count, vecs[v].cnt);
      release_result();
    end

    // Result held under backpressure: 2*5 + 4*4
    issue(16'd2, 16'd5, 1'b0, t);
    issue(16'd4, 16'd4, 1'b1, t_last);
    idle();
    wait_result(t_last);
    check("hold_sum", bus0.out_sum, 64'd26);
    check("hold_cnt", bus0.out_count, 64'd2);
    s0 = 64'(bus0.out_sum);
    c0 = 64'(bus0.out_count);
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!bus0.out_valid || bus0.in_ready || 64'(bus0.out_sum) != s0 ||
          64'(bus0.out_count) != c0) seen = 1;
    end
    check("hold_stable", seen, 1'b0);
    check("hold_sum_end", bus0.out_sum, 64'd26);
    release_result();

    // Reset while draining discards the vector
    issue(16'd5, 16'd5, 1'b0, t);
    issue(16'd6, 16'd6, 1'b1, t_last);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", bus0.in_ready, 1'b1);
    check("midrst_out_valid", bus0.out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus0.out_valid || bus1.out_valid) seen = 1;
    end
    check("midrst_no_result", seen, 1'b0);
    issue(16'd2, 16'd2, 1'b1, t_last);
    idle();
    wait_result(t_last);
    check("postrst_sum", bus0.out_sum, 64'd4);
    check("postrst_cnt", bus0.out_count, 64'd1);
    release_result();

    // Bubbles between beats, then in_valid held while in_ready is low
    issue(16'd6, 16'd7, 1'b0, t);
    repeat (3) idle();
    issue(16'd8, 16'd9, 1'b1, t_last);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      op_a     = 16'd100;
      op_b     = 16'd100;
    end
    idle();
    wait_result(t_last);
    check("bubble_sum", bus0.out_sum, 64'd114);
    check("bubble_cnt", bus0.out_count, 64'd2);
    check("bubble_ovf", bus0.out_overflow, 1'b0);
    release_result();
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus0.out_valid) seen = 1;
    end
    check("ignored_beats_no_result", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dot_accumulate.md
Name: dot_accumulate

Overview:
- Downstream consumer of the pipelined multiplier: sums a variable-length vector of products into one dot-product result.
- Accepts the per-beat issue handshake that launches each operand pair into the multiplier.
- Tracks the multiplier latency internally with a valid/last delay line, then accumulates the multiplier's product output.
- Presents the finished sum on a valid/ready output interface.

Parameters:
- WIDTH, 16, operand width of the upstream multiplier; product input is 2*WIDTH bits.
- PIPE_STAGES, 5, multiplier latency in cycles. Must equal the multiplier's PIPE_STAGES, and must be at least 1.
- ACC_WIDTH, 40, accumulator width. Must be at least 2*WIDTH.
- CNT_WIDTH, 16, term-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair presented to multiplier this cycle
- in_last  in  1  this beat is the final term of the vector
- in_ready  out  1  block can accept a beat; the issuer launches operands only when in_valid && in_ready
- product  in  2*WIDTH  multiplier result, unsigned
- out_valid  out  1  out_sum/out_count/out_overflow valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  ACC_WIDTH  unsigned dot-product sum
- out_count  out  CNT_WIDTH  number of terms summed
- out_overflow  out  1  sticky: carry out of ACC_WIDTH occurred in this vector

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, count=0, delay line cleared, out_valid=0, out_sum=0, out_count=0, out_overflow=0.
- Accepted beat: in_valid && in_ready at cycle t. Its product is valid on the product input during cycle t+PIPE_STAGES.
- Delay line: PIPE_STAGES flops of {valid,last}, stage 0 loaded with {in_valid&&in_ready, in_last}. The tap at the last stage qualifies product.
- Accumulation on tap valid:
  - acc <= acc + zero-extended product, wrapping modulo 2^ACC_WIDTH.
  - Carry out sets a sticky overflow bit.
  - count increments and saturates at all-ones.
- FSM states:
  - IDLE (acc=0).
  - ACCUM: beats issued, no last yet.
  - DRAIN: last issued, in flight.
  - HOLD: result presented.
- FSM transitions:
  - IDLE -> ACCUM on accepted non-last beat.
  - IDLE or ACCUM -> DRAIN on accepted last beat.
  - DRAIN -> HOLD when the tap shows valid && last.
  - HOLD -> IDLE on out_ready.
- in_ready = (state==IDLE || state==ACCUM), decoded from registered state.
- HOLD exit: in_ready stays low in the cycle out_ready is sampled and rises the next cycle.
- Result capture, on the edge where the last product is consumed:
  - out_sum = acc + product.
  - out_count = count+1 (saturating).
  - out_overflow includes any carry from this final add.
  - acc, count and the sticky bit clear to 0 for the next vector.
- Latency: last beat accepted at t -> out_valid high from cycle t+PIPE_STAGES+1.
- out_valid holds, with outputs stable, until out_ready is sampled high. It then deasserts the following cycle.
- Single-beat vector (in_last on the first beat) is legal: IDLE -> DRAIN directly.
- Bubbles (in_valid low between beats) are legal; the sum is unaffected.
- Beats after last cannot be issued because in_ready is low. This guarantees no product of the next vector mixes into the current sum.
- in_valid while in_ready is low: ignored, nothing enters the delay line.
- Reset mid-operation clears the delay line and FSM. The multiplier's unreset pipeline contents are never qualified, so stale products are discarded.
- product is sampled only on tap-valid cycles; X on other cycles is harmless.

Decomposition:
- Package dot_acc_pkg:
  - state enum dot_acc_state_t {IDLE, ACCUM, DRAIN, HOLD}
  - default widths DOT_ACC_WIDTH=40, DOT_CNT_WIDTH=16
- Sub-module valid_delay_line:
  - Parameters DEPTH, W.
  - Async active-low reset shift register carrying {valid,last}.
  - Reusable for other fixed-latency datapaths.

Test Plan:
1. Single beat a=3,b=4, in_last=1 at cycle 0 (PIPE_STAGES=5) -> out_valid rises cycle 6, out_sum=12, out_count=1, out_overflow=0; in_ready low cycles 1-6.
2. Four back-to-back beats (1,2),(3,4),(5,6),(7,8) with last on the fourth -> out_sum=100, out_count=4, out_valid rises 6 cycles after last beat.
3. Vector 2*5 + 4*4, out_ready held low 10 cycles after out_valid -> out_valid, out_sum=26 and out_count=2 stable throughout, in_ready low. After out_ready=1: out_valid low next cycle, in_ready high next cycle.
4. ACC_WIDTH=32, two beats 0xFFFF*0xFFFF -> out_sum=0xFFFC0002, out_overflow=1. A following vector 1*1 -> out_sum=1, out_overflow=0.
5. rst_n pulsed low while in DRAIN (two cycles after last issued) -> out_valid never asserts for that vector. Next vector 2*2 single beat -> out_sum=4, out_count=1.
6. Beats (6,7) and (8,9) separated by 3 idle cycles, with in_valid asserted while in_ready low during DRAIN -> out_sum=114, out_count=2; the ignored in_valid does not affect the result.
